// File: rtl/rf_writeback_ctrl.sv
// ============================================================================
// rf_writeback_ctrl: register-file writeback arbiter with load-result FIFO
//   and busy scoreboard for load-use hazard stalls.  Rev 1.0
// ============================================================================
`default_nettype none

module rf_writeback_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  q_ra1,
  input  logic [4:0]  q_ra2,
  input  logic [4:0]  q_wa,
  output logic        stall,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [36:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic             we_load;

  logic             push;
  logic             pop;
  logic             sel_valid;
  logic             sel_load;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  logic             sel_write;

  assign lsu_ready = rst_n && (count < CNT_FULL);
  assign push      = lsu_valid && lsu_ready;

  // ALU results have no back-pressure, so they always win arbitration.
  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = 32'd0;
    pop       = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (count != '0) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = mem[rd_ptr][36:32];
      sel_data  = mem[rd_ptr][31:0];
      pop       = 1'b1;
    end
  end

  assign sel_write = sel_valid && (sel_rd != 5'd0);

  // Clear first, then set, so a same-cycle issue to the written register wins.
  always_comb begin
    busy_next = busy;
    if (we && we_load) begin
      busy_next[wa] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  assign stall = rst_n && (((q_ra1 != 5'd0) && busy[q_ra1]) ||
                           ((q_ra2 != 5'd0) && busy[q_ra2]) ||
                           ((q_wa  != 5'd0) && busy[q_wa]));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {lsu_rd, lsu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      busy    <= 32'd0;
      we      <= 1'b0;
      we_load <= 1'b0;
      wa      <= 5'd0;
      wd      <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      we      <= sel_write;
      we_load <= sel_write && sel_load;
      if (sel_write) begin
        wa <= sel_rd;
        wd <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_ctrl.sv
// ============================================================================
// tb_rf_writeback_ctrl: cycle-by-cycle directed vectors for rf_writeback_ctrl.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_rf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  q_ra1;
  logic [4:0]  q_ra2;
  logic [4:0]  q_wa;
  logic        stall;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .q_ra1      (q_ra1),
    .q_ra2      (q_ra2),
    .q_wa       (q_wa),
    .stall      (stall),
    .we         (we),
    .wa         (wa),
    .wd         (wd)
  );

  // One record per clock cycle: inputs for the cycle, plus the outputs seen
  // mid-cycle (registered ones reflect earlier edges, ready/stall this cycle).
  typedef struct {
    logic        rn;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  w;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_st;
  } vec_t;

  function automatic vec_t v(
    input logic rn, input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
    input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic e_rdy, input logic e_st);
    vec_t t;
    t.rn = rn; t.av = av; t.ard = ard; t.ad = ad;
    t.lv = lv; t.lrd = lrd; t.ld = ld; t.iv = iv; t.ird = ird;
    t.r1 = r1; t.r2 = r2; t.w = w;
    t.e_we = e_we; t.e_wa = e_wa; t.e_wd = e_wd; t.e_rdy = e_rdy; t.e_st = e_st;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t t);
    rst_n       = t.rn;
    alu_valid   = t.av;
    alu_rd      = t.ard;
    alu_data    = t.ad;
    lsu_valid   = t.lv;
    lsu_rd      = t.lrd;
    lsu_data    = t.ld;
    issue_valid = t.iv;
    issue_rd    = t.ird;
    q_ra1       = t.r1;
    q_ra2       = t.r2;
    q_wa        = t.w;
    @(negedge clk);
    check({tag, " we"},        {31'd0, we},        {31'd0, t.e_we});
    check({tag, " lsu_ready"}, {31'd0, lsu_ready}, {31'd0, t.e_rdy});
    check({tag, " stall"},     {31'd0, stall},     {31'd0, t.e_st});
    if (t.e_we) begin
      check({tag, " wa"}, {27'd0, wa}, {27'd0, t.e_wa});
      check({tag, " wd"}, wd, t.e_wd);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];

  initial begin
    //            rn av ard  ad            lv lrd ld         iv ird r1 r2 w   we wa wd            rdy st
    tbl[0]  = v(0, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  7, 0, 0,  0, 0, 32'h0,        0, 0);
    tbl[1]  = v(1, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,     0, 0,  0, 0, 0,  0, 0, 32'h0,        1, 0);
    tbl[2]  = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  0, 0, 0,  1, 5, 32'hDEADBEEF, 1, 0);
    tbl[3]  = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     1, 7,  7, 0, 0,  0, 0, 32'h0,        1, 0);
    tbl[4]  = v(1, 0, 0, 32'h0,        1, 7,  32'h1234,  0, 0,  7, 0, 0,  0, 0, 32'h0,        1, 1);
    tbl[5]  = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  7, 0, 0,  0, 0, 32'h0,        1, 1);
    tbl[6]  = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  7, 0, 0,  1, 7, 32'h1234,     1, 1);
    tbl[7]  = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  7, 0, 0,  0, 0, 32'h0,        1, 0);
    tbl[8]  = v(1, 1, 0, 32'h55,       1, 0,  32'h66,    0, 0,  0, 0, 0,  0, 0, 32'h0,        1, 0);
    tbl[9]  = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  0, 0, 0,  0, 0, 32'h0,        1, 0);
    tbl[10] = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  0, 0, 0,  0, 0, 32'h0,        1, 0);
    tbl[11] = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     1, 9,  0, 0, 0,  0, 0, 32'h0,        1, 0);
    tbl[12] = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  0, 9, 0,  0, 0, 32'h0,        1, 1);
    tbl[13] = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  0, 0, 9,  0, 0, 32'h0,        1, 1);
    tbl[14] = v(1, 0, 0, 32'h0,        0, 0,  32'h0,     0, 0,  0, 0, 0,  0, 0, 32'h0,        1, 0);

    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; q_ra1 = '0; q_ra2 = '0; q_wa = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Continuous ALU traffic starves the FIFO; the third load must be refused.
    run_vec("full0", v(1, 1, 1, 32'd100, 1, 10, 32'hA0A0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    1, 0));
    run_vec("full1", v(1, 1, 2, 32'd101, 1, 11, 32'hB0B0, 0, 0, 0, 0, 0, 1, 1, 32'd100,  1, 0));
    run_vec("full2", v(1, 1, 3, 32'd102, 1, 12, 32'hC0C0, 0, 0, 0, 0, 0, 1, 2, 32'd101,  0, 0));
    run_vec("full3", v(1, 1, 4, 32'd103, 1, 12, 32'hC0C0, 0, 0, 0, 0, 0, 1, 3, 32'd102,  0, 0));
    run_vec("full4", v(1, 0, 0, 32'h0,   0, 0,  32'h0,    0, 0, 0, 0, 0, 1, 4, 32'd103,  0, 0));
    run_vec("full5", v(1, 0, 0, 32'h0,   0, 0,  32'h0,    0, 0, 0, 0, 0, 1, 10, 32'hA0A0, 1, 0));
    run_vec("full6", v(1, 0, 0, 32'h0,   0, 0,  32'h0,    0, 0, 0, 0, 0, 1, 11, 32'hB0B0, 1, 0));
    run_vec("full7", v(1, 0, 0, 32'h0,   0, 0,  32'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0,    1, 0));

    // Re-issue to rd 3 on the edge that retires the load to rd 3: set wins.
    run_vec("setclr0", v(1, 0, 0, 32'h0, 0, 0, 32'h0,  1, 3, 0, 0, 0, 0, 0, 32'h0,  1, 0));
    run_vec("setclr1", v(1, 0, 0, 32'h0, 1, 3, 32'h33, 0, 0, 3, 0, 0, 0, 0, 32'h0,  1, 1));
    run_vec("setclr2", v(1, 0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 3, 0, 0, 0, 0, 32'h0,  1, 1));
    run_vec("setclr3", v(1, 0, 0, 32'h0, 0, 0, 32'h0,  1, 3, 3, 0, 0, 1, 3, 32'h33, 1, 1));
    run_vec("setclr4", v(1, 0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 3, 0, 0, 0, 0, 32'h0,  1, 1));
    run_vec("setclr5", v(1, 0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 3, 0, 0, 0, 0, 32'h0,  1, 1));

    // Reset with two buffered loads and busy bits 3 and 9 pending.
    run_vec("rst0", v(1, 1, 1, 32'd1, 1, 20, 32'h20, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
    run_vec("rst1", v(1, 1, 1, 32'd1, 1, 21, 32'h21, 0, 0, 0, 0, 0, 1, 1, 32'd1, 1, 0));
    run_vec("rst2", v(0, 0, 0, 32'h0, 1, 22, 32'h22, 0, 0, 3, 9, 0, 1, 1, 32'd1, 0, 0));
    run_vec("rst3", v(1, 0, 0, 32'h0, 0, 0,  32'h0,  0, 0, 3, 0, 9, 0, 0, 32'h0, 1, 0));
    run_vec("rst4", v(1, 0, 0, 32'h0, 0, 0,  32'h0,  0, 0, 0, 3, 0, 0, 0, 32'h0, 1, 0));
    run_vec("rst5", v(1, 0, 0, 32'h0, 0, 0,  32'h0,  0, 0, 9, 0, 3, 0, 0, 32'h0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
